// File: rtl/y_line_buffer_pkg.sv
// y_line_buffer_pkg
//   Shared types, constants and helpers for the five-row vertical line buffer.
//   PIXEL_W  : bits per pixel.
//   NUM_ROWS : number of row slots (four stored rows plus the live row).
//   col_w()  : width of the column counter for a given row length.
//   next_slot(): modulo-5 slot increment used for the write slot and hsel.
package y_line_buffer_pkg;

    localparam int PIXEL_W  = 8;
    localparam int NUM_ROWS = 5;

    typedef logic [PIXEL_W-1:0] pixel_t;
    typedef logic [2:0]         slot_t;

    // Column counter width; a row of WIDTH pixels is addressed 0..WIDTH-1.
    function automatic int col_w(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

    // Slot rotation 0,1,2,3,4,0,...
    function automatic slot_t next_slot(input slot_t s);
        return (s == slot_t'(NUM_ROWS - 1)) ? slot_t'(0) : s + slot_t'(1);
    endfunction

endpackage

// File: rtl/y_line_buffer_if.sv
// y_line_buffer_if
//   Pixel stream in and five-row column out of the vertical line buffer.
//   Handshake: a pixel is transferred on every rising clock edge where
//   validin=1 (sof is only meaningful together with validin). There is no
//   ready/backpressure; validout is a one-cycle strobe that the consumer
//   must take on the cycle it is high.
//   din/validin/sof       : source -> buffer
//   dout0..dout4/hsel/validout : buffer -> vertical window
//   Modports: master = pixel source / column sink, slave = line buffer.
interface y_line_buffer_if;
    import y_line_buffer_pkg::*;

    pixel_t din;
    logic   validin;
    logic   sof;
    pixel_t dout0;
    pixel_t dout1;
    pixel_t dout2;
    pixel_t dout3;
    pixel_t dout4;
    slot_t  hsel;
    logic   validout;

    modport master (
        output din, validin, sof,
        input  dout0, dout1, dout2, dout3, dout4, hsel, validout
    );

    modport slave (
        input  din, validin, sof,
        output dout0, dout1, dout2, dout3, dout4, hsel, validout
    );

endinterface

// File: rtl/y_line_buffer_line_ram.sv
// y_line_buffer_line_ram
//   One row of pixel storage: DEPTH x PIXEL_W, one write port and one
//   synchronous read port sharing a single address. A read and a write to
//   the same address in the same cycle return the old contents.
//   Ports:
//     clk, rst_n : clock, async active-low reset (read register only)
//     we, wdata  : write enable / write data
//     re         : read enable; rdata holds when re=0
//     addr       : shared address
//     rdata      : registered read data
module y_line_buffer_line_ram
    import y_line_buffer_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  pixel_t        wdata,
    output pixel_t        rdata
);

    pixel_t mem [DEPTH];
    pixel_t rdata_q;
    pixel_t rdata_d;

    // Storage array is never reset; contents are undefined after reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    // Read register is reset so the column outputs read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/y_line_buffer.sv
// y_line_buffer
//   Five-row circular line buffer feeding a 5-tap vertical filter window.
//   Each accepted pixel is written into the current write slot at its
//   column address while the other four slots are read at the same address.
//   One cycle later dout0..dout4 present the vertical column (slot k on
//   doutk) and hsel names the slot holding the oldest row. Rows are never
//   moved; only the write slot rotates at the end of each row.
//   Ports:
//     clock, reset_n : rising-edge clock, async active-low reset
//     bus (slave)    : din/validin/sof in, dout0..4/hsel/validout out
//   Parameter WIDTH: pixels per row, 8..2048.
module y_line_buffer
    import y_line_buffer_pkg::*;
#(
    parameter int WIDTH = 640
) (
    input  logic             clock,
    input  logic             reset_n,
    y_line_buffer_if.slave   bus
);

    localparam int            CW       = col_w(WIDTH);
    localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);
    localparam logic [2:0]    FULL     = 3'(NUM_ROWS - 1);

    logic [CW-1:0] col_q, col_d;
    slot_t         wr_sel_q, wr_sel_d;
    logic [2:0]    rows_done_q, rows_done_d;
    slot_t         byp_sel_q, byp_sel_d;
    slot_t         hsel_q, hsel_d;
    logic          validout_q, validout_d;
    pixel_t        din_q, din_d;

    // Effective slot/column for this pixel: sof forces slot 0, column 0.
    slot_t         eff_sel;
    logic [CW-1:0] eff_col;

    pixel_t        rd_data [NUM_ROWS];
    pixel_t        col_out [NUM_ROWS];

    always_comb begin
        col_d       = col_q;
        wr_sel_d    = wr_sel_q;
        rows_done_d = rows_done_q;
        byp_sel_d   = byp_sel_q;
        hsel_d      = hsel_q;
        din_d       = din_q;
        validout_d  = 1'b0;
        eff_sel     = wr_sel_q;
        eff_col     = col_q;

        if (bus.validin) begin
            din_d = bus.din;
            if (bus.sof) begin
                // Restart the frame; partial rows are simply abandoned.
                eff_sel     = '0;
                eff_col     = '0;
                col_d       = CW'(1);
                wr_sel_d    = '0;
                rows_done_d = '0;
                byp_sel_d   = '0;
                hsel_d      = next_slot(slot_t'(0));
            end else begin
                byp_sel_d  = wr_sel_q;
                hsel_d     = next_slot(wr_sel_q);
                validout_d = (rows_done_q == FULL);
                if (col_q == LAST_COL) begin
                    col_d       = '0;
                    wr_sel_d    = next_slot(wr_sel_q);
                    rows_done_d = (rows_done_q == FULL) ? rows_done_q
                                                        : rows_done_q + 3'd1;
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            col_q       <= '0;
            wr_sel_q    <= '0;
            rows_done_q <= '0;
            byp_sel_q   <= '0;
            hsel_q      <= '0;
            validout_q  <= 1'b0;
            din_q       <= '0;
        end else begin
            col_q       <= col_d;
            wr_sel_q    <= wr_sel_d;
            rows_done_q <= rows_done_d;
            byp_sel_q   <= byp_sel_d;
            hsel_q      <= hsel_d;
            validout_q  <= validout_d;
            din_q       <= din_d;
        end
    end

    for (genvar k = 0; k < NUM_ROWS; k++) begin : g_ram
        y_line_buffer_line_ram #(
            .DEPTH (WIDTH),
            .AW    (CW)
        ) u_ram (
            .clk   (clock),
            .rst_n (reset_n),
            .we    (bus.validin && (eff_sel == slot_t'(k))),
            .re    (bus.validin),
            .addr  (eff_col),
            .wdata (bus.din),
            .rdata (rd_data[k])
        );
    end

    // The slot being written this pixel reads stale data, so its column
    // entry comes from the registered incoming pixel instead.
    always_comb begin
        for (int k = 0; k < NUM_ROWS; k++) begin
            col_out[k] = (byp_sel_q == slot_t'(k)) ? din_q : rd_data[k];
        end
    end

    assign bus.dout0    = col_out[0];
    assign bus.dout1    = col_out[1];
    assign bus.dout2    = col_out[2];
    assign bus.dout3    = col_out[3];
    assign bus.dout4    = col_out[4];
    assign bus.hsel     = hsel_q;
    assign bus.validout = validout_q;

endmodule
